modular_exponentiation: RTL and testbench

Computes base^exponent mod modulus for the ElGamal datapath by sequencing modular multiplications on an external `multiplication_modulo` instance. It sits directly upstream of that multiplier: it accepts one job on three AXI-Stream-style input channels and issues multiply requests over the multiplier's three-channel handshake. It consumes the multiplier's results and returns one SIZE-bit result per job on an output stream.

---
 rtl/elgamal_pkg.sv | 24 ++
 rtl/modular_exponentiation.sv | 146 ++++++++++++++
 tb/tb_modular_exponentiation.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/elgamal_pkg.sv
// elgamal_pkg: shared width default, FSM encoding and handshake helpers for the ElGamal datapath.
package elgamal_pkg;

    localparam int DEFAULT_SIZE = 64;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REDUCE_SEND = 3'd1,
        REDUCE_WAIT = 3'd2,
        MUL_SEND    = 3'd3,
        MUL_WAIT    = 3'd4,
        SQR_SEND    = 3'd5,
        SQR_WAIT    = 3'd6,
        DONE        = 3'd7
    } state_t;

    localparam logic HS_ON  = 1'b1;
    localparam logic HS_OFF = 1'b0;

    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/modular_exponentiation.sv
// modular_exponentiation: right-to-left binary base^exponent mod modulus, sequencing an external modular multiplier.
module modular_exponentiation
    import elgamal_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   input_base_tdata,
    input  logic              input_base_tvalid,
    output logic              input_base_tready,
    input  logic [SIZE-1:0]   input_exponent_tdata,
    input  logic              input_exponent_tvalid,
    output logic              input_exponent_tready,
    input  logic [SIZE-1:0]   input_modulus_tdata,
    input  logic              input_modulus_tvalid,
    output logic              input_modulus_tready,
    output logic [SIZE-1:0]   mul_multiplier_tdata,
    output logic              mul_multiplier_tvalid,
    input  logic              mul_multiplier_tready,
    output logic [SIZE-1:0]   mul_multiplicand_tdata,
    output logic              mul_multiplicand_tvalid,
    input  logic              mul_multiplicand_tready,
    output logic [2*SIZE-1:0] mul_modulus_tdata,
    output logic              mul_modulus_tvalid,
    input  logic              mul_modulus_tready,
    input  logic [2*SIZE-1:0] mul_result_tdata,
    input  logic              mul_result_tvalid,
    output logic              mul_result_tready,
    output logic [SIZE-1:0]   output_tdata,
    output logic              output_tvalid,
    input  logic              output_tready
);

    state_t state;
    logic [SIZE-1:0] b, r, e, m, b_n, e_n, m_n, res;
    logic have_b, have_e, have_m, fb, fe, fm, all_n, send_done, res_fire;
    logic unused_hi;

    assign fb = fire(input_base_tvalid, input_base_tready);
    assign fe = fire(input_exponent_tvalid, input_exponent_tready);
    assign fm = fire(input_modulus_tvalid, input_modulus_tready);
    assign b_n = fb ? input_base_tdata : b;
    assign e_n = fe ? input_exponent_tdata : e;
    assign m_n = fm ? input_modulus_tdata : m;
    assign all_n = (have_b | fb) & (have_e | fe) & (have_m | fm);
    assign send_done = (~mul_multiplier_tvalid | mul_multiplier_tready) &
                       (~mul_multiplicand_tvalid | mul_multiplicand_tready) &
                       (~mul_modulus_tvalid | mul_modulus_tready);
    assign res_fire = fire(mul_result_tvalid, mul_result_tready);
    // Results are always below the modulus, so the upper half carries nothing.
    assign res = mul_result_tdata[SIZE-1:0];
    assign unused_hi = ^mul_result_tdata[2*SIZE-1:SIZE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            {b, r, e, m} <= '0;
            {have_b, have_e, have_m} <= '0;
            {input_base_tready, input_exponent_tready, input_modulus_tready} <= '0;
            {mul_multiplier_tdata, mul_multiplicand_tdata, mul_modulus_tdata} <= '0;
            {mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid} <= '0;
            mul_result_tready <= HS_OFF;
            output_tdata <= '0;
            output_tvalid <= HS_OFF;
        end else begin
            case (state)
                IDLE: begin
                    {b, e, m} <= {b_n, e_n, m_n};
                    have_b <= ~all_n & (have_b | fb);
                    have_e <= ~all_n & (have_e | fe);
                    have_m <= ~all_n & (have_m | fm);
                    input_base_tready <= ~all_n & ~(have_b | fb);
                    input_exponent_tready <= ~all_n & ~(have_e | fe);
                    input_modulus_tready <= ~all_n & ~(have_m | fm);
                    if (all_n && m_n[SIZE-1:1] == '0) begin
                        r <= '0;
                        output_tdata <= '0;
                        output_tvalid <= HS_ON;
                        state <= DONE;
                    end else if (all_n) begin
                        mul_multiplier_tdata <= b_n;
                        mul_multiplicand_tdata <= SIZE'(1);
                        mul_modulus_tdata <= {{SIZE{1'b0}}, m_n};
                        {mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid} <= {3{HS_ON}};
                        state <= REDUCE_SEND;
                    end
                end
                REDUCE_SEND, MUL_SEND, SQR_SEND: begin
                    if (fire(mul_multiplier_tvalid, mul_multiplier_tready)) mul_multiplier_tvalid <= HS_OFF;
                    if (fire(mul_multiplicand_tvalid, mul_multiplicand_tready)) mul_multiplicand_tvalid <= HS_OFF;
                    if (fire(mul_modulus_tvalid, mul_modulus_tready)) mul_modulus_tvalid <= HS_OFF;
                    if (send_done) begin
                        mul_result_tready <= HS_ON;
                        state <= state == REDUCE_SEND ? REDUCE_WAIT : state == MUL_SEND ? MUL_WAIT : SQR_WAIT;
                    end
                end
                REDUCE_WAIT: if (res_fire) begin
                    mul_result_tready <= HS_OFF;
                    b <= res;
                    r <= SIZE'(1);
                    if (e == '0) begin
                        output_tdata <= SIZE'(1);
                        output_tvalid <= HS_ON;
                        state <= DONE;
                    end else begin
                        mul_multiplier_tdata <= e[0] ? SIZE'(1) : res;
                        mul_multiplicand_tdata <= res;
                        {mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid} <= {3{HS_ON}};
                        state <= e[0] ? MUL_SEND : SQR_SEND;
                    end
                end
                MUL_WAIT: if (res_fire) begin
                    mul_result_tready <= HS_OFF;
                    r <= res;
                    if (e[SIZE-1:1] == '0) begin
                        output_tdata <= res;
                        output_tvalid <= HS_ON;
                        state <= DONE;
                    end else begin
                        mul_multiplier_tdata <= b;
                        mul_multiplicand_tdata <= b;
                        {mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid} <= {3{HS_ON}};
                        state <= SQR_SEND;
                    end
                end
                // The bit examined next is e[1], which becomes e[0] after this shift.
                SQR_WAIT: if (res_fire) begin
                    mul_result_tready <= HS_OFF;
                    b <= res;
                    e <= e >> 1;
                    mul_multiplier_tdata <= e[1] ? r : res;
                    mul_multiplicand_tdata <= res;
                    {mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid} <= {3{HS_ON}};
                    state <= e[1] ? MUL_SEND : SQR_SEND;
                end
                DONE: if (fire(output_tvalid, output_tready)) begin
                    output_tvalid <= HS_OFF;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modular_exponentiation.sv
// tb_modular_exponentiation: scoreboard bench with a behavioural modular multiplier wired back to back.
module tb_modular_exponentiation;
    import elgamal_pkg::*;

    localparam int W = 64;

    logic clk = 0, rst = 1;
    logic [W-1:0] input_base_tdata = '0, input_exponent_tdata = '0, input_modulus_tdata = '0;
    logic input_base_tvalid = 0, input_exponent_tvalid = 0, input_modulus_tvalid = 0;
    logic input_base_tready, input_exponent_tready, input_modulus_tready;
    logic [W-1:0] mul_multiplier_tdata, mul_multiplicand_tdata;
    logic [2*W-1:0] mul_modulus_tdata, mul_result_tdata;
    logic mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid, mul_result_tvalid;
    logic mul_multiplier_tready, mul_multiplicand_tready, mul_modulus_tready, mul_result_tready;
    logic [W-1:0] output_tdata;
    logic output_tvalid, output_tready = 0;

    int checks = 0, errors = 0;
    int txns = 0, pulses = 0;
    logic mv_d = 0;
    bit mul_stall = 0;
    logic [W-1:0] exp_q[$];
    logic ga, gb, gm;
    logic [W-1:0] ma, mb;
    logic [2*W-1:0] mm;

    always #5 clk = ~clk;

    modular_exponentiation #(.SIZE(W)) dut (
        .clk(clk), .rst(rst),
        .input_base_tdata(input_base_tdata), .input_base_tvalid(input_base_tvalid), .input_base_tready(input_base_tready),
        .input_exponent_tdata(input_exponent_tdata), .input_exponent_tvalid(input_exponent_tvalid), .input_exponent_tready(input_exponent_tready),
        .input_modulus_tdata(input_modulus_tdata), .input_modulus_tvalid(input_modulus_tvalid), .input_modulus_tready(input_modulus_tready),
        .mul_multiplier_tdata(mul_multiplier_tdata), .mul_multiplier_tvalid(mul_multiplier_tvalid), .mul_multiplier_tready(mul_multiplier_tready),
        .mul_multiplicand_tdata(mul_multiplicand_tdata), .mul_multiplicand_tvalid(mul_multiplicand_tvalid), .mul_multiplicand_tready(mul_multiplicand_tready),
        .mul_modulus_tdata(mul_modulus_tdata), .mul_modulus_tvalid(mul_modulus_tvalid), .mul_modulus_tready(mul_modulus_tready),
        .mul_result_tdata(mul_result_tdata), .mul_result_tvalid(mul_result_tvalid), .mul_result_tready(mul_result_tready),
        .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready)
    );

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] m);
        logic [2*W-1:0] p;
        if (m == 0) return '0;
        p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % m;
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] powmod(input logic [W-1:0] bb, input logic [W-1:0] ee, input logic [W-1:0] mm_i);
        logic [2*W-1:0] r, bm, md;
        if (mm_i < 2) return '0;
        md = {{W{1'b0}}, mm_i};
        bm = {{W{1'b0}}, bb} % md;
        r = 1;
        for (longint unsigned i = 0; i < ee; i++) r = (r * bm) % md;
        return r[W-1:0];
    endfunction

    function automatic int exp_txns(input logic [W-1:0] ee, input logic [W-1:0] mm_i);
        int pc, msb;
        if (mm_i < 2) return 0;
        if (ee == 0) return 1;
        pc = 0;
        msb = 0;
        for (int i = 0; i < W; i++) if (ee[i]) begin pc++; msb = i; end
        return 1 + pc + msb;
    endfunction

    // Behavioural multiplier: one-cycle latency, optional random stalls on its request channels.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {ga, gb, gm} <= '0;
            ma <= '0; mb <= '0; mm <= '0;
            {mul_multiplier_tready, mul_multiplicand_tready, mul_modulus_tready} <= '0;
            mul_result_tvalid <= 0;
            mul_result_tdata <= '0;
        end else begin
            if (mul_multiplier_tvalid && mul_multiplier_tready) begin ma <= mul_multiplier_tdata; ga <= 1; end
            if (mul_multiplicand_tvalid && mul_multiplicand_tready) begin mb <= mul_multiplicand_tdata; gb <= 1; end
            if (mul_modulus_tvalid && mul_modulus_tready) begin mm <= mul_modulus_tdata; gm <= 1; end
            if (ga && gb && gm) begin
                mul_result_tdata <= {{W{1'b0}}, mulmod(ma, mb, mm)};
                mul_result_tvalid <= 1;
                {ga, gb, gm} <= '0;
            end else if (mul_result_tvalid && mul_result_tready) mul_result_tvalid <= 0;
            mul_multiplier_tready <= !(ga || (mul_multiplier_tvalid && mul_multiplier_tready)) && (!mul_stall || $urandom_range(0, 1) == 1);
            mul_multiplicand_tready <= !(gb || (mul_multiplicand_tvalid && mul_multiplicand_tready)) && (!mul_stall || $urandom_range(0, 1) == 1);
            mul_modulus_tready <= !(gm || (mul_modulus_tvalid && mul_modulus_tready)) && (!mul_stall || $urandom_range(0, 1) == 1);
        end
    end

    always @(posedge clk) begin
        mv_d <= mul_multiplier_tvalid | mul_multiplicand_tvalid | mul_modulus_tvalid;
        if ((mul_multiplier_tvalid | mul_multiplicand_tvalid | mul_modulus_tvalid) && !mv_d) pulses <= pulses + 1;
        if (mul_result_tvalid && mul_result_tready) txns <= txns + 1;
    end

    task automatic send_inputs(input logic [W-1:0] bb, input logic [W-1:0] ee, input logic [W-1:0] mm_i, input int d0, input int d1, input int d2);
        fork
            begin
                repeat (d0) @(negedge clk);
                input_base_tdata = bb;
                input_base_tvalid = 1;
                for (int k = 0; k < 2000 && !input_base_tready; k++) @(negedge clk);
                @(negedge clk);
                input_base_tvalid = 0;
            end
            begin
                repeat (d1) @(negedge clk);
                input_exponent_tdata = ee;
                input_exponent_tvalid = 1;
                for (int k = 0; k < 2000 && !input_exponent_tready; k++) @(negedge clk);
                @(negedge clk);
                input_exponent_tvalid = 0;
            end
            begin
                repeat (d2) @(negedge clk);
                input_modulus_tdata = mm_i;
                input_modulus_tvalid = 1;
                for (int k = 0; k < 2000 && !input_modulus_tready; k++) @(negedge clk);
                @(negedge clk);
                input_modulus_tvalid = 0;
            end
        join
    endtask

    task automatic run_job(input string name, input logic [W-1:0] bb, input logic [W-1:0] ee, input logic [W-1:0] mm_i,
                           input int d0, input int d1, input int d2, input int ostall);
        logic [W-1:0] got, want;
        int t0, p0, et, k;
        et = exp_txns(ee, mm_i);
        exp_q.push_back(powmod(bb, ee, mm_i));
        t0 = txns;
        p0 = pulses;
        send_inputs(bb, ee, mm_i, d0, d1, d2);
        k = 0;
        while (!output_tvalid && k < 20000) begin @(negedge clk); k++; end
        checks++;
        if (!output_tvalid) begin
            errors++;
            $display("FAIL %s_timeout output_tvalid=%b want 1", name, output_tvalid);
            want = exp_q.pop_front();
            return;
        end
        got = output_tdata;
        if (ostall > 0) begin
            checks++;
            if ({input_base_tready, input_exponent_tready, input_modulus_tready} !== 3'b000) begin
                errors++;
                $display("FAIL %s_in_ready got %b want 000", name, {input_base_tready, input_exponent_tready, input_modulus_tready});
            end
        end
        for (int i = 0; i < ostall; i++) begin
            @(negedge clk);
            checks++;
            if (output_tvalid !== 1'b1 || output_tdata !== got) begin
                errors++;
                $display("FAIL %s_stall cycle %0d got valid=%b data=%0d want valid=1 data=%0d", name, i, output_tvalid, output_tdata, got);
            end
        end
        output_tready = 1;
        @(negedge clk);
        output_tready = 0;
        checks++;
        if (output_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_drop got %b want 0", name, output_tvalid);
        end
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s_result got %0d want %0d", name, got, want);
        end
        checks++;
        if (txns - t0 != et) begin
            errors++;
            $display("FAIL %s_txns got %0d want %0d", name, txns - t0, et);
        end
        checks++;
        if (pulses - p0 != et) begin
            errors++;
            $display("FAIL %s_pulses got %0d want %0d", name, pulses - p0, et);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({input_base_tready, input_exponent_tready, input_modulus_tready, mul_result_tready} !== 4'b0) begin
            errors++;
            $display("FAIL %s_readys got %b want 0000", name, {input_base_tready, input_exponent_tready, input_modulus_tready, mul_result_tready});
        end
        checks++;
        if ({mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid, output_tvalid} !== 4'b0) begin
            errors++;
            $display("FAIL %s_valids got %b want 0000", name, {mul_multiplier_tvalid, mul_multiplicand_tvalid, mul_modulus_tvalid, output_tvalid});
        end
        checks++;
        if ((|{output_tdata, mul_multiplier_tdata, mul_multiplicand_tdata, mul_modulus_tdata}) !== 1'b0) begin
            errors++;
            $display("FAIL %s_data got nonzero want all zero", name);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        @(negedge clk);
        checks++;
        if ({input_base_tready, input_exponent_tready, input_modulus_tready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 111", {input_base_tready, input_exponent_tready, input_modulus_tready});
        end
    endtask

    task automatic test_basic();
        run_job("basic", 64'd4, 64'd13, 64'd497, 0, 0, 0, 0);
        run_job("zero_exp", 64'd5, 64'd0, 64'd7, 0, 0, 0, 0);
        run_job("reduce", 64'd100, 64'd3, 64'd7, 0, 0, 0, 0);
    endtask

    task automatic test_small_modulus();
        run_job("mod_one", 64'd12345, 64'd77, 64'd1, 0, 0, 0, 0);
        run_job("mod_zero", 64'd9, 64'd5, 64'd0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        mul_stall = 1;
        run_job("backpressure", 64'd3, 64'd200, 64'd1009, 0, 3, 7, 20);
        mul_stall = 0;
    endtask

    task automatic test_reset_mid();
        int k;
        send_inputs(64'd3, 64'd200, 64'd1009, 0, 0, 0);
        k = 0;
        while (dut.state != MUL_WAIT && k < 5000) begin @(negedge clk); k++; end
        checks++;
        if (dut.state != MUL_WAIT) begin
            errors++;
            $display("FAIL reset_mid_reach got state %0d want %0d", dut.state, MUL_WAIT);
        end
        rst = 1;
        @(negedge clk);
        check_all_zero("reset_mid");
        rst = 0;
        @(negedge clk);
        run_job("after_reset", 64'd2, 64'd10, 64'd1000, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        mul_stall = 1;
        for (int j = 0; j < 4; j++)
            run_job("random", {$urandom, $urandom}, 64'($urandom_range(1, 300)), {$urandom, $urandom} | 64'd2,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        mul_stall = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_modulus();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
